// File: rtl/loop_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : loop_seq_pkg
//  Brief   : Shared types and constants for the nested-loop sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
package loop_seq_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BODY      = 3'd1,
    S_INNER_CHK = 3'd2,
    S_OUTER_CHK = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Reported reason for leaving the loop nest.
  typedef enum logic [1:0] {
    EXIT_NORMAL    = 2'd0,
    EXIT_OUTER_BRK = 2'd1,
    EXIT_RSVD2     = 2'd2,
    EXIT_RSVD3     = 2'd3
  } exit_t;

  // Loop level targeted by a break/continue.
  localparam logic LVL_INNER = 1'b0;
  localparam logic LVL_OUTER = 1'b1;

endpackage : loop_seq_pkg
`default_nettype wire

// File: rtl/loop_seq_if.sv
`default_nettype none
// ============================================================================
//  Module  : loop_seq_if
//  Brief   : Control/handshake bundle between a loop-sequencer host and the
//            sequencer itself.
//  Revision: 1.0 - initial release
// ============================================================================
interface loop_seq_if #(
  parameter int CNT_W = 8,
  parameter int TOT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] outer_max;
  logic [CNT_W-1:0] inner_max;
  logic             body_req;
  logic             body_ack;
  logic             ctl_brk;
  logic             ctl_cont;
  logic             ctl_lvl;
  logic [CNT_W-1:0] outer_idx;
  logic [CNT_W-1:0] inner_idx;
  logic [TOT_W-1:0] iter_total;
  logic             busy;
  logic             done;
  logic [1:0]       exit_code;

  // Host side: launches the nest and answers body requests.
  modport master (
    output start, outer_max, inner_max, body_ack, ctl_brk, ctl_cont, ctl_lvl,
    input  body_req, outer_idx, inner_idx, iter_total, busy, done, exit_code
  );

  // Sequencer side.
  modport slave (
    input  start, outer_max, inner_max, body_ack, ctl_brk, ctl_cont, ctl_lvl,
    output body_req, outer_idx, inner_idx, iter_total, busy, done, exit_code
  );
endinterface : loop_seq_if
`default_nettype wire

// File: rtl/loop_seq_ctr.sv
`default_nettype none
// ============================================================================
//  Module  : loop_seq_ctr
//  Brief   : Loop index register with limit latch, clear, increment and a
//            "another iteration remains" compare.
//  Revision: 1.0 - initial release
// ============================================================================
module loop_seq_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,     // latch limit and clear index
  input  logic [CNT_W-1:0] lim_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] idx_o,
  output logic             more_o    // idx+1 < limit
);

  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] lim_q;

  // Index and limit registers; load has priority over clear and increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      lim_q <= '0;
    end else if (ld_i) begin
      idx_q <= '0;
      lim_q <= lim_i;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (inc_i) begin
      idx_q <= idx_q + CNT_W'(1);
    end
  end

  // One extra bit so an all-ones limit cannot wrap the compare.
  always_comb begin
    more_o = ({1'b0, idx_q} + (CNT_W+1)'(1)) < {1'b0, lim_q};
  end

  assign idx_o = idx_q;

endmodule : loop_seq_ctr
`default_nettype wire

// File: rtl/loop_seq.sv
`default_nettype none
// ============================================================================
//  Module  : loop_seq
//  Brief   : Two-level do-while loop sequencer with break/continue control and
//            a saturating executed-body counter.
//  Revision: 1.0 - initial release
// ============================================================================
module loop_seq
  import loop_seq_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TOT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  loop_seq_if.slave  bus
);

  state_t           state_q, state_d;
  exit_t            exit_q,  exit_d;
  logic [TOT_W-1:0] tot_q,   tot_d;

  logic ld;
  logic in_inc, in_clr, out_inc;
  logic in_more, out_more;

  loop_seq_ctr #(.CNT_W(CNT_W)) u_inner (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_i   (ld),
    .lim_i  (bus.inner_max),
    .clr_i  (in_clr),
    .inc_i  (in_inc),
    .idx_o  (bus.inner_idx),
    .more_o (in_more)
  );

  loop_seq_ctr #(.CNT_W(CNT_W)) u_outer (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_i   (ld),
    .lim_i  (bus.outer_max),
    .clr_i  (1'b0),
    .inc_i  (out_inc),
    .idx_o  (bus.outer_idx),
    .more_o (out_more)
  );

  // State, exit code and body counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      exit_q  <= EXIT_NORMAL;
      tot_q   <= '0;
    end else begin
      state_q <= state_d;
      exit_q  <= exit_d;
      tot_q   <= tot_d;
    end
  end

  // Next-state logic and index control strobes.
  always_comb begin
    state_d = state_q;
    exit_d  = exit_q;
    tot_d   = tot_q;
    ld      = 1'b0;
    in_inc  = 1'b0;
    in_clr  = 1'b0;
    out_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ld      = 1'b1;
          tot_d   = '0;
          exit_d  = EXIT_NORMAL;
          state_d = S_BODY;
        end
      end
      S_BODY: begin
        if (bus.body_ack) begin
          if (tot_q != {TOT_W{1'b1}}) tot_d = tot_q + TOT_W'(1);
          // Break outranks continue when both are raised.
          if (bus.ctl_brk) begin
            if (bus.ctl_lvl == LVL_OUTER) begin
              exit_d  = EXIT_OUTER_BRK;
              state_d = S_DONE;
            end else begin
              state_d = S_OUTER_CHK;
            end
          end else if (bus.ctl_cont && bus.ctl_lvl == LVL_OUTER) begin
            state_d = S_OUTER_CHK;
          end else begin
            state_d = S_INNER_CHK;
          end
        end
      end
      S_INNER_CHK: begin
        if (in_more) begin
          in_inc  = 1'b1;
          state_d = S_BODY;
        end else begin
          state_d = S_OUTER_CHK;
        end
      end
      S_OUTER_CHK: begin
        if (out_more) begin
          out_inc = 1'b1;
          in_clr  = 1'b1;
          state_d = S_BODY;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the state register so reset clears them at once.
  assign bus.body_req   = (state_q == S_BODY);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.iter_total = tot_q;
  assign bus.exit_code  = exit_q;

endmodule : loop_seq
`default_nettype wire

// File: tb/tb_loop_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_loop_seq
//  Brief   : Scoreboard bench for the loop sequencer: the driver pushes the
//            expected body indices and completion status, the monitor pops and
//            compares whenever a body is acknowledged or done pulses.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_loop_seq;

  localparam int CNT_W = 8;
  localparam int TOT_W = 5;   // narrow so saturation is reachable

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  loop_seq_if #(.CNT_W(CNT_W), .TOT_W(TOT_W)) ifc ();

  loop_seq #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int exp_body[$];   // o*256 + i
  int exp_done[$];   // total*4 + exit

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic push_b(input int o, input int i_lo, input int i_hi);
    for (int i = i_lo; i <= i_hi; i++) exp_body.push_back(o * 256 + i);
  endtask

  // Monitor: compares every acknowledged body and every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.body_req && ifc.body_ack) begin
        tests++;
        if (exp_body.size() == 0) begin
          fails++;
          $display("FAIL body_unexpected got (o,i)=(%0d,%0d)", ifc.outer_idx, ifc.inner_idx);
        end else begin
          int e;
          e = exp_body.pop_front();
          if ({24'd0, ifc.outer_idx} != e / 256 || {24'd0, ifc.inner_idx} != e % 256) begin
            fails++;
            $display("FAIL body_idx got (o,i)=(%0d,%0d) expected (%0d,%0d)",
                     ifc.outer_idx, ifc.inner_idx, e / 256, e % 256);
          end
        end
      end
      if (ifc.done) begin
        tests++;
        if (exp_done.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected total=%0d exit=%0d", ifc.iter_total, ifc.exit_code);
        end else begin
          int e;
          e = exp_done.pop_front();
          if ({27'd0, ifc.iter_total} != e / 4 || {30'd0, ifc.exit_code} != e % 4) begin
            fails++;
            $display("FAIL done_status got total=%0d exit=%0d expected total=%0d exit=%0d",
                     ifc.iter_total, ifc.exit_code, e / 4, e % 4);
          end
        end
        check("bodies_left_at_done", exp_body.size(), 0);
      end
    end
  end

  function automatic int all_outs();
    return {ifc.body_req, ifc.busy, ifc.done} + ifc.outer_idx + ifc.inner_idx
           + ifc.iter_total + ifc.exit_code;
  endfunction

  // Launch one nest and answer bodies. ctl_n selects which body (ack order) carries
  // brk/cont; all_cont puts an inner continue on every body; stall delays each ack a
  // cycle; rst_at pulls reset while that body is requested.
  task automatic run(input int omax, input int imax, input int ctl_n, input bit c_brk,
                     input bit c_cont, input bit c_lvl, input bit all_cont, input bit stall,
                     input int rst_at, input int exp_tot, input int exp_exit);
    int  n = 0;
    bit  fin = 0;
    bit  st = 0;
    if (rst_at < 0) exp_done.push_back(exp_tot * 4 + exp_exit);
    ifc.start     = 1'b1;
    ifc.outer_max = CNT_W'(omax);
    ifc.inner_max = CNT_W'(imax);
    @(posedge clk); #1;
    ifc.start = 1'b0;
    check("busy_after_start", int'(ifc.busy), 1);
    for (int c = 0; c < 3000 && !fin; c++) begin
      ifc.body_ack = 1'b0; ifc.ctl_brk = 1'b0; ifc.ctl_cont = 1'b0; ifc.ctl_lvl = 1'b0;
      if (ifc.done) begin
        fin = 1;
      end else if (ifc.body_req) begin
        if (n == rst_at) begin
          rst_n = 1'b0;
          #2;
          check("async_reset_outs", all_outs(), 0);
          fin = 1;
        end else if (stall && !st) begin
          st = 1;
        end else begin
          ifc.body_ack = 1'b1;
          if (all_cont) ifc.ctl_cont = 1'b1;
          if (n == ctl_n) begin
            ifc.ctl_brk = c_brk; ifc.ctl_cont = c_cont; ifc.ctl_lvl = c_lvl;
          end
          st = 0;
          n++;
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    if (!fin) begin
      tests++; fails++;
      $display("FAIL timeout omax=%0d imax=%0d", omax, imax);
    end else if (rst_at < 0) begin
      @(posedge clk); #1;
      check("done_one_cycle", int'(ifc.done), 0);
      check("idle_after_done", int'(ifc.busy), 0);
      check("total_held", int'(ifc.iter_total), exp_tot);
      check("exit_held", int'(ifc.exit_code), exp_exit);
    end
  endtask

  initial begin
    ifc.start = 1'b0; ifc.outer_max = '0; ifc.inner_max = '0;
    ifc.body_ack = 1'b0; ifc.ctl_brk = 1'b0; ifc.ctl_cont = 1'b0; ifc.ctl_lvl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outs", all_outs(), 0);

    // 2x3 plain acks
    push_b(0, 0, 2); push_b(1, 0, 2);
    run(2, 3, -1, 0, 0, 0, 0, 0, -1, 6, 0);
    // zero limits: one body
    push_b(0, 0, 0);
    run(0, 0, -1, 0, 0, 0, 0, 0, -1, 1, 0);
    // inner break on (0,1)
    push_b(0, 0, 1); push_b(1, 0, 2);
    run(2, 3, 1, 1, 0, 0, 0, 0, -1, 5, 0);
    // outer continue on (0,0)
    push_b(0, 0, 0); push_b(1, 0, 2);
    run(2, 3, 0, 0, 1, 1, 0, 0, -1, 4, 0);
    // outer break on (0,0)
    push_b(0, 0, 0);
    run(2, 3, 0, 1, 0, 1, 0, 0, -1, 1, 1);
    // brk and cont together at inner level act as inner break
    push_b(0, 0, 0); push_b(1, 0, 2);
    run(2, 3, 0, 1, 1, 0, 0, 0, -1, 4, 0);
    // inner continue on every body, with stalled acks
    push_b(0, 0, 2); push_b(1, 0, 2);
    run(2, 3, -1, 0, 0, 0, 1, 1, -1, 6, 0);
    // 1x1 with stall
    push_b(0, 0, 0);
    run(1, 1, -1, 0, 0, 0, 0, 1, -1, 1, 0);
    // 3x1
    push_b(0, 0, 0); push_b(1, 0, 0); push_b(2, 0, 0);
    run(3, 1, -1, 0, 0, 0, 0, 0, -1, 3, 0);
    // 4x8 = 32 bodies, counter saturates at 31
    for (int o = 0; o < 4; o++) push_b(o, 0, 7);
    run(4, 8, -1, 0, 0, 0, 0, 0, -1, 31, 0);
    // all-ones inner limit: 255 bodies
    push_b(0, 0, 254);
    run(1, 255, -1, 0, 0, 0, 0, 0, -1, 31, 0);
    // reset while body (1,1) is requested
    push_b(0, 0, 2); push_b(1, 0, 0);
    run(2, 3, -1, 0, 0, 0, 0, 0, 4, 0, 0);
    #3;
    check("in_reset_outs", all_outs(), 0);
    check("bodies_left_after_reset", exp_body.size(), 0);
    rst_n = 1'b1;
    #1;
    // fresh run right after reset release
    push_b(0, 0, 2); push_b(1, 0, 2);
    run(2, 3, -1, 0, 0, 0, 0, 0, -1, 6, 0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_bodies_empty", exp_body.size(), 0);
    check("scoreboard_done_empty", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_loop_seq
`default_nettype wire

// File: doc/loop_seq.md
LOOP_SEQ -- requirements
Module: loop_seq

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of iteration limits and indices.
REQ-002 Parameter TOT_W, default 16, SHALL set the width of the executed-body counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 start  input  1  launch request; SHALL be sampled only in IDLE.
REQ-006 outer_max  input  CNT_W  outer loop limit; SHALL be latched on an accepted start.
REQ-007 inner_max  input  CNT_W  inner loop limit; SHALL be latched on an accepted start.
REQ-008 body_req  output  1  body execution request; SHALL be high only in BODY.
REQ-009 body_ack  input  1  body complete; SHALL be ignored unless body_req=1.
REQ-010 ctl_brk  input  1  break, qualified by body_ack.
REQ-011 ctl_cont  input  1  continue, qualified by body_ack.
REQ-012 ctl_lvl  input  1  target loop level for brk/cont: 0=inner, 1=outer.
REQ-013 outer_idx, inner_idx  output  CNT_W each  current loop indices.
REQ-014 iter_total  output  TOT_W  count of acknowledged bodies.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 exit_code  output  2  0=normal exit, 1=outer break; 2 and 3 reserved.

Function
REQ-018 FSM states SHALL be IDLE, BODY, INNER_CHK, OUTER_CHK, DONE.
REQ-019 Loop semantics SHALL be do-while: each body executes before its condition is tested, so a limit of 0 or 1 gives exactly one execution and N>=1 gives N.
REQ-020 IDLE with start=1 SHALL go to BODY on the next cycle, clear both indices, iter_total and exit_code, and latch both limits; start while busy SHALL be ignored.
REQ-021 BODY SHALL hold until body_ack=1; ack is legal in the first BODY cycle; each ack SHALL increment iter_total, saturating at all-ones.
REQ-022 Ack with no control, or with ctl_cont and ctl_lvl=0, SHALL go to INNER_CHK.
REQ-023 Ack with ctl_brk and ctl_lvl=0, or with ctl_cont and ctl_lvl=1, SHALL go to OUTER_CHK and skip the remaining inner iterations.
REQ-024 Ack with ctl_brk and ctl_lvl=1 SHALL go to DONE with exit_code=1.
REQ-025 If ctl_brk and ctl_cont are both high, brk SHALL win.
REQ-026 INNER_CHK: if inner_idx+1 < inner_max, SHALL increment inner_idx and go to BODY; otherwise go to OUTER_CHK.
REQ-027 OUTER_CHK: if outer_idx+1 < outer_max, SHALL increment outer_idx, clear inner_idx and go to BODY; otherwise go to DONE.
REQ-028 Index compares SHALL be done at CNT_W+1 bits so that limit all-ones does not wrap.
REQ-029 DONE SHALL assert done for exactly one cycle, then go to IDLE; indices, iter_total and exit_code SHALL hold until the next accepted start.
REQ-030 Minimum inner iteration SHALL be 2 cycles (BODY + INNER_CHK); an inner-to-outer transition SHALL add 1 cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, with body_req, busy, done, indices, iter_total and exit_code all 0, including in the middle of an operation.
REQ-032 After rst_n deassertion, the first start SHALL be accepted on the first clock edge.

Structure
REQ-033 Package loop_seq_pkg SHALL hold the state enum, the exit_code enum and the LVL_INNER/LVL_OUTER constants.
REQ-034 One sub-module, loop_seq_ctr, SHALL implement an index register with clear, increment and a limit compare, instantiated for the inner and outer loops.

Verification
REQ-035 outer_max=2, inner_max=3, plain acks -> 6 bodies in (o,i) order (0,0)..(1,2), iter_total=6, exit_code=0, one done pulse.
REQ-036 outer_max=0, inner_max=0 -> exactly 1 body, iter_total=1, done.
REQ-037 outer_max=2, inner_max=3, inner brk on body (0,1) -> bodies (0,0),(0,1),(1,0),(1,1),(1,2), iter_total=5.
REQ-038 outer_max=2, inner_max=3, outer cont on (0,0) -> iter_total=4; outer brk on (0,0) -> iter_total=1, exit_code=1.
REQ-039 brk and cont both high with ctl_lvl=0 on (0,0) -> behaves as inner brk; inner cont on every body -> iter_total=6.
REQ-040 rst_n low during BODY at (1,1) -> all outputs 0 asynchronously; a new start then runs normally from (0,0).
